rr_arb_mux: RTL

- Parametrised, registered N-channel, W-bit multiplexer with per-channel valid/ready handshake.
- Selects among requesting input channels in one of two modes:
  - round-robin arbitration;
  - fixed select, the legacy sel-driven mux behaviour.
- Presents the chosen beat on a single registered output stream.
- Sits between multiple producers and one shared consumer (bus, UART TX, display path).

---
 rtl/rr_arb_mux.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-channel mux with per-channel valid/ready handshake.
// Channel selection is either round-robin (rotating pointer) or fixed (fixed_sel).
// The output stage is a one-entry register that refills in the same cycle it drains.
// Optional build macro RR_MUX_LAST_EN adds in_last/out_last and locks the grant to a
// channel until that channel's last beat has been transferred.
module rr_arb_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
`ifdef RR_MUX_LAST_EN
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_last,
`endif
    input  logic                     mode_fixed,
    input  logic [SEL_W-1:0]         fixed_sel,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    // Channel count at index width + 1, so ptr + offset never overflows before wrapping.
    localparam logic [SEL_W:0] NUM_CH_X = (SEL_W+1)'(NUM_CH);

    logic [SEL_W-1:0]  ptr_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [SEL_W-1:0]  out_ch_r;

    logic              load_s;
    logic              grant_vld_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic              xfer_s;
    logic              eff_fixed_s;
    logic              final_s;
    logic              lock_act_s;
    logic [SEL_W-1:0]  lock_ch_s;
    logic [SEL_W-1:0]  ptr_next_s;
    logic [SEL_W:0]    cand_s;
    logic              hit_s;

`ifdef RR_MUX_LAST_EN
    logic              lock_r;
    logic              lock_fixed_r;
    logic [SEL_W-1:0]  lock_ch_r;
    logic              out_last_r;

    // While locked, the mode captured at lock time stays in force for the whole packet.
    assign eff_fixed_s = lock_r ? lock_fixed_r : mode_fixed;
    assign final_s     = in_last[grant_idx_s];
    assign lock_act_s  = lock_r;
    assign lock_ch_s   = lock_ch_r;
    assign out_last    = out_last_r;
`else
    assign eff_fixed_s = mode_fixed;
    assign final_s     = 1'b1;
    assign lock_act_s  = 1'b0;
    assign lock_ch_s   = '0;
`endif

    // Output register can accept a new beat when it is empty or being drained now.
    assign load_s     = !out_valid_r || out_ready;
    assign xfer_s     = load_s && grant_vld_s;
    assign ptr_next_s = ({1'b0, grant_idx_s} == (NUM_CH_X - (SEL_W+1)'(1))) ? '0
                                                                             : (grant_idx_s + SEL_W'(1));

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;

    // Grant selection: locked channel, fixed channel, or first requester from ptr onward.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        if (lock_act_s) begin
            grant_vld_s = in_valid[lock_ch_s];
            grant_idx_s = lock_ch_s;
        end else if (eff_fixed_s) begin
            if ({1'b0, fixed_sel} < NUM_CH_X) begin
                grant_vld_s = in_valid[fixed_sel];
                grant_idx_s = fixed_sel;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cand_s      = {1'b0, ptr_r} + (SEL_W+1)'(k);
                cand_s      = (cand_s >= NUM_CH_X) ? (cand_s - NUM_CH_X) : cand_s;
                hit_s       = !grant_vld_s && in_valid[cand_s[SEL_W-1:0]];
                grant_idx_s = hit_s ? cand_s[SEL_W-1:0] : grant_idx_s;
                grant_vld_s = grant_vld_s || hit_s;
            end
        end
    end

    // One-hot accept to the granted channel; nothing is accepted while in reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && xfer_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Output beat register: load on transfer, empty on idle load, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[grant_idx_s*DATA_W +: DATA_W];
            out_ch_r    <= grant_idx_s;
        end else if (load_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Round-robin pointer moves past the winner only when a packet completes in rr mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (xfer_s && !eff_fixed_s && final_s) begin
            ptr_r <= ptr_next_s;
        end
    end

`ifdef RR_MUX_LAST_EN
    // Packet lock: engage on a non-last beat, release on the last beat; out_last follows data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r       <= 1'b0;
            lock_fixed_r <= 1'b0;
            lock_ch_r    <= '0;
            out_last_r   <= 1'b0;
        end else if (xfer_s) begin
            lock_r       <= !final_s;
            lock_fixed_r <= eff_fixed_s;
            lock_ch_r    <= grant_idx_s;
            out_last_r   <= final_s;
        end
    end
`endif

endmodule
